// File: rtl/fifo_lookahead_adapter.sv
// fifo_lookahead_adapter
// Turns a conventional FIFO (data valid one cycle after the read strobe) into
// a first-word-fall-through interface. A small circular prefetch buffer holds
// words read ahead from upstream. The head word is always presented on dout.
//
// Optional feature: define FIFO_LOOKAHEAD_ADAPTER_ERR_EN to add a sticky err
// output. err is set by any rd issued while the lookahead side is empty.

module fifo_lookahead_adapter #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   _empty,
    output logic                   _rd,
    input  logic [DATA_WIDTH-1:0]  _dout,
    output logic                   empty,
    input  logic                   rd,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic [LEVEL_WIDTH-1:0] level
`ifdef FIFO_LOOKAHEAD_ADAPTER_ERR_EN
    ,
    output logic                   err
`endif
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    // One extra bit so the occupancy projection can reach DEPTH without wrapping.
    localparam int SUM_WIDTH = LEVEL_WIDTH + 1;

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [LEVEL_WIDTH-1:0] level_r;
    logic                   inflight_r;

    logic                   empty_s;
    logic                   pop_s;
    logic                   up_rd_s;
    logic                   up_acc_s;
    logic [SUM_WIDTH-1:0]   projected_s;

    // Occupancy projection and upstream read decision.
    // projected_s is the level after this edge: it counts the word already in
    // flight, because that word is guaranteed to land. A pop is only accepted
    // when level_r is non-zero, so the subtraction cannot underflow.
    always_comb begin
        empty_s     = (level_r == {LEVEL_WIDTH{1'b0}});
        pop_s       = rd && !empty_s;
        projected_s = SUM_WIDTH'(level_r) + SUM_WIDTH'(inflight_r) - SUM_WIDTH'(pop_s);
        up_rd_s     = 1'b0;
        if (rst) begin
            up_rd_s = 1'b0;
        end else if (!_empty && (projected_s < SUM_WIDTH'(DEPTH))) begin
            up_rd_s = 1'b1;
        end else begin
            up_rd_s = 1'b0;
        end
        up_acc_s = up_rd_s && !_empty;
    end

    // Pointer, level and in-flight tracking.
    // A simultaneous write and pop leave the level unchanged and move both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_WIDTH{1'b0}};
            wr_ptr_r   <= {PTR_WIDTH{1'b0}};
            level_r    <= {LEVEL_WIDTH{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= up_acc_s;
            level_r    <= projected_s[LEVEL_WIDTH-1:0];
            if (inflight_r) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1'b1);
            end
        end
    end

    // Capture the upstream word one cycle after its read was accepted.
    // The RAM has no reset. Gating with rst drops a word that is still in
    // flight when reset arrives.
    always_ff @(posedge clk) begin
        if (inflight_r && !rst) begin
            mem_r[wr_ptr_r] <= _dout;
        end
    end

`ifdef FIFO_LOOKAHEAD_ADAPTER_ERR_EN
    logic err_r;

    // Sticky underflow flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (rd && empty_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`endif

    assign _rd   = up_rd_s;
    assign empty = empty_s;
    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule
